multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the RV32I datapath around the decoder: fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), drives the memory request
// handshakes and the IR/PC/regfile write strobes, and counts retired
// instructions. A bounded wait counter turns a stalled memory into a
// sticky fault.
//
// Optional feature macro: SEQ_TRAP_ILLEGAL_EN
//   defined   : an unknown opcode in EXEC halts the sequencer and sets trap
//   undefined : an unknown opcode retires as a NOP and trap stays 0
module multicycle_sequencer #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      inst,
  input  logic             RegWr,
  input  logic             Branch,
  input  logic             MemWr,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             err,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Last wait count that still allows one more cycle of waiting.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t           state_reg, state_next;
  logic [7:0]       wait_reg, wait_next;
  logic [CNT_W-1:0] instret_reg;
  logic             err_reg, err_next;
  logic             trap_reg, trap_next;
  logic             retire;

  logic [6:0] opcode;
  logic       is_load, is_store, is_jal, is_jalr, is_legal;
  logic       trap_hit;
  logic       wait_expired;
  logic       unused_inst_bits;

  assign opcode   = inst[6:0];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_legal = (opcode == OP_REG)    || (opcode == OP_IMM)   ||
                    (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                    (opcode == OP_BRANCH) || (opcode == OP_JALR)  ||
                    (opcode == OP_JAL)    || (opcode == OP_AUIPC) ||
                    (opcode == OP_LUI);

  // Only the opcode field steers sequencing; the rest of IR feeds the datapath.
  assign unused_inst_bits = ^inst[31:7];

`ifdef SEQ_TRAP_ILLEGAL_EN
  assign trap_hit = !is_legal;
`else
  assign trap_hit = 1'b0;
`endif

  // Memory has had its last chance: this cycle is the WAIT_MAX-th wait.
  assign wait_expired = (wait_reg == WAIT_LAST);

  // Next-state, wait counter, sticky faults and the Moore/strobe outputs.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    err_next   = err_reg;
    trap_next  = trap_reg;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    rf_we      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end

      S_DECODE: begin
        state_next = S_EXEC;
      end

      S_EXEC: begin
        if (trap_hit) begin
          state_next = S_HALT;
          trap_next  = 1'b1;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (Branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
          retire = 1'b1;
        end else begin
          state_next = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = MemWr;
        if (mem_ready) begin
          if (is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_expired) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end

      S_WB: begin
        // Unknown opcodes reach here only as NOPs: no regfile write.
        rf_we  = RegWr && is_legal;
        pc_we  = 1'b1;
        pc_sel = is_jal ? PC_IMM : (is_jalr ? PC_ALU : PC_PLUS4);
        retire = 1'b1;
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (retire) begin
      state_next = run ? S_FETCH : S_IDLE;
    end

    // Every fresh memory request starts with an empty wait budget.
    if ((state_next != state_reg) && ((state_next == S_FETCH) || (state_next == S_MEM))) begin
      wait_next = 8'd0;
    end
  end

  // State, wait counter, retire counter and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      wait_reg    <= 8'd0;
      instret_reg <= '0;
      err_reg     <= 1'b0;
      trap_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      err_reg   <= err_next;
      trap_reg  <= trap_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  assign state   = state_reg;
  assign instret = instret_reg;
  assign err     = err_reg;
  assign trap    = trap_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction is
// described at transaction level (opcode, decoded flags, memory delays)
// and the expected per-cycle trace is derived from the sequencing rules.
// Honours SEQ_TRAP_ILLEGAL_EN when the same macro is defined for the build.
module tb_multicycle_sequencer;

  localparam int CW = 4;
  localparam int WM = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_AU  = 7'b0010111;
  localparam logic [6:0] OP_LU  = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic          clk = 1'b0;
  logic          rst, run, RegWr, Branch, MemWr, branch_taken, mem_ready;
  logic [31:0]   inst;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, err, trap;
  logic [1:0]    pc_sel;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference-model sticky state
  logic [CW-1:0] m_instret;
  logic          m_err, m_trap;

  always #5 clk = ~clk;

  multicycle_sequencer #(.CNT_W(CW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .RegWr(RegWr), .Branch(Branch),
    .MemWr(MemWr), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .state(state),
    .instret(instret), .err(err), .trap(trap)
  );

  typedef struct {
    logic [6:0] op;
    logic rw, br, mw, tk;
    int   fdly, mdly;
    int   cyc;
    logic [1:0] psel;
    logic rfw;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [2:0] st, input logic im, dm, dw, iw, pw,
                     input logic [1:0] ps, input logic rw);
    logic [16:0] act, want;
    act  = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, err, trap, instret};
    want = {st, im, dm, dw, iw, pw, ps, rw, m_err, m_trap, m_instret};
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h (state,imem,dmem,dwe,irwe,pcwe,pcsel,rfwe,err,trap,instret)",
                  nm, act, want);
    $display("cycle %s: state=%0d instret=%0d", nm, state, instret);
  endtask

  task automatic chk_val(input string nm, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, want);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    m_instret = '0; m_err = 1'b0; m_trap = 1'b0;
    #1;
    chk("reset", 3'd0, 0, 0, 0, 0, 0, 2'b00, 0);
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      run = 1'b0; mem_ready = 1'($urandom);
      #1;
      chk("idle", 3'd0, 0, 0, 0, 0, 0, 2'b00, 0);
    end
  endtask

  task automatic idle_go();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'($urandom);
    #1;
    chk("idle_go", 3'd0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  // Runs one instruction starting in FETCH; expected trace derived from
  // the opcode class and the chosen memory delays.
  task automatic do_instr(input logic [6:0] op, input logic rw, br, mw, tk,
                          input int fdly, mdly, input logic run_after, input logic rnd,
                          output int ncyc, output logic [1:0] ret_psel,
                          output logic rf_seen, output logic stopped);
    logic is_ld, is_st, legal, done, ret, br_ret;
    logic [1:0] ps;
    is_ld  = (op == OP_LD);
    is_st  = (op == OP_ST);
    legal  = op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JR, OP_J, OP_AU, OP_LU};
    br_ret = !(is_ld || is_st) && br;
`ifdef SEQ_TRAP_ILLEGAL_EN
    br_ret = br_ret && legal;
`endif
    ncyc = 0; ret_psel = 2'b00; rf_seen = 1'b0; stopped = 1'b0; done = 1'b0;

    for (int i = 0; i < WM && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        inst = $urandom; inst[6:0] = op;
        RegWr = rw; Branch = br; MemWr = mw; branch_taken = tk;
      end
      mem_ready = (i == fdly);
      if (rnd) run = 1'($urandom);
      #1; ncyc++;
      chk("fetch", 3'd1, 1, 0, 0, mem_ready, 0, 2'b00, 0);
      if (mem_ready) done = 1'b1;
    end
    if (!done) begin
      m_err = 1'b1; stopped = 1'b1;
      @(negedge clk); mem_ready = 1'($urandom); #1;
      chk("fetch_timeout", 3'd6, 0, 0, 0, 0, 0, 2'b00, 0);
      return;
    end

    @(negedge clk);
    mem_ready = 1'($urandom);
    if (rnd) run = 1'($urandom);
    #1; ncyc++;
    chk("decode", 3'd2, 0, 0, 0, 0, 0, 2'b00, 0);

    @(negedge clk);
    mem_ready = 1'($urandom);
    if (br_ret) run = run_after;
    else if (rnd) run = 1'($urandom);
    #1; ncyc++;
`ifdef SEQ_TRAP_ILLEGAL_EN
    if (!legal) begin
      chk("exec_illegal", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0);
      m_trap = 1'b1; stopped = 1'b1;
      @(negedge clk); #1;
      chk("trap_halt", 3'd6, 0, 0, 0, 0, 0, 2'b00, 0);
      return;
    end
`endif
    if (is_ld || is_st) begin
      chk("exec_mem", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0);
    end else if (br) begin
      ps = tk ? 2'b01 : 2'b00;
      chk("exec_branch", 3'd3, 0, 0, 0, 0, 1, ps, 0);
      ret_psel = pc_sel; rf_seen = rf_we;
      m_instret = m_instret + 1'b1;
      return;
    end else begin
      chk("exec_alu", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0);
    end

    if (is_ld || is_st) begin
      done = 1'b0;
      for (int i = 0; i < WM && !done; i++) begin
        @(negedge clk);
        mem_ready = (i == mdly);
        ret = mem_ready && is_st;
        if (ret) run = run_after;
        else if (rnd) run = 1'($urandom);
        #1; ncyc++;
        chk("mem", 3'd4, 0, 1, mw, 0, ret, 2'b00, 0);
        rf_seen = rf_seen | rf_we;
        if (ret) ret_psel = pc_sel;
        if (mem_ready) done = 1'b1;
      end
      if (!done) begin
        m_err = 1'b1; stopped = 1'b1;
        @(negedge clk); mem_ready = 1'($urandom); #1;
        chk("mem_timeout", 3'd6, 0, 0, 0, 0, 0, 2'b00, 0);
        return;
      end
      if (is_st) begin
        m_instret = m_instret + 1'b1;
        return;
      end
    end

    @(negedge clk);
    mem_ready = 1'($urandom);
    run = run_after;
    #1; ncyc++;
    ps = (op == OP_J) ? 2'b01 : ((op == OP_JR) ? 2'b10 : 2'b00);
    chk("wb", 3'd5, 0, 0, 0, 0, 1, ps, rw && legal);
    rf_seen = rf_seen | rf_we;
    ret_psel = pc_sel;
    m_instret = m_instret + 1'b1;
  endtask

  int         ncyc;
  logic [1:0] rps;
  logic       rfs, stp;

  initial begin
    rst = 1'b1; run = 1'b0; inst = '0; RegWr = 1'b0; Branch = 1'b0; MemWr = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b0;
    m_instret = '0; m_err = 1'b0; m_trap = 1'b0;

    //        op     rw br mw tk fd md cyc psel  rfw
    tbl[0]  = '{OP_I,  1, 0, 0, 0, 0, 0, 4, 2'b00, 1};
    tbl[1]  = '{OP_LD, 1, 0, 0, 0, 0, 3, 8, 2'b00, 1};
    tbl[2]  = '{OP_ST, 0, 0, 1, 0, 0, 0, 4, 2'b00, 0};
    tbl[3]  = '{OP_BR, 0, 1, 0, 1, 0, 0, 3, 2'b01, 0};
    tbl[4]  = '{OP_BR, 0, 1, 0, 0, 0, 0, 3, 2'b00, 0};
    tbl[5]  = '{OP_J,  1, 0, 0, 0, 0, 0, 4, 2'b01, 1};
    tbl[6]  = '{OP_JR, 1, 0, 0, 0, 0, 0, 4, 2'b10, 1};
    tbl[7]  = '{OP_LU, 1, 0, 0, 0, 2, 0, 6, 2'b00, 1};
    tbl[8]  = '{OP_ST, 0, 0, 1, 0, 0, 3, 7, 2'b00, 0};
    tbl[9]  = '{OP_I,  1, 0, 0, 0, 3, 0, 7, 2'b00, 1};
    tbl[10] = '{OP_AU, 1, 0, 0, 0, 1, 0, 5, 2'b00, 1};

    do_reset();
    idle_cycles(2);
    idle_go();

    // Table-driven instruction classes, back to back with run held high
    for (int t = 0; t < 11; t++) begin
      do_instr(tbl[t].op, tbl[t].rw, tbl[t].br, tbl[t].mw, tbl[t].tk,
               tbl[t].fdly, tbl[t].mdly, 1'b1, 1'b0, ncyc, rps, rfs, stp);
      chk_val($sformatf("tbl%0d_cycles", t), ncyc, tbl[t].cyc);
      chk_val($sformatf("tbl%0d_pc_sel", t), int'(rps), int'(tbl[t].psel));
      chk_val($sformatf("tbl%0d_rf_we", t), int'(rfs), int'(tbl[t].rfw));
    end

    // Randomized legal traffic (illegal opcodes only when they retire as NOPs)
    for (int r = 0; r < 150; r++) begin
      logic [6:0] op;
      logic ra;
      int sel;
`ifdef SEQ_TRAP_ILLEGAL_EN
      sel = $urandom_range(0, 8);
`else
      sel = $urandom_range(0, 9);
`endif
      case (sel)
        0: op = OP_R;  1: op = OP_I;  2: op = OP_LD; 3: op = OP_ST; 4: op = OP_BR;
        5: op = OP_JR; 6: op = OP_J;  7: op = OP_AU; 8: op = OP_LU;
        default: op = OP_BAD;
      endcase
      ra = ($urandom_range(0, 3) != 0);
      do_instr(op, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, WM - 1), $urandom_range(0, WM - 1), ra, 1'b1,
               ncyc, rps, rfs, stp);
      if (!ra) begin
        idle_cycles($urandom_range(1, 2));
        idle_go();
      end
    end

    // Illegal opcode
    do_reset();
    idle_go();
    do_instr(OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, ncyc, rps, rfs, stp);
`ifdef SEQ_TRAP_ILLEGAL_EN
    chk_val("illegal_halted", int'(stp), 1);
    @(negedge clk); run = 1'b1; #1;
    chk("illegal_stays_halt", 3'd6, 0, 0, 0, 0, 0, 2'b00, 0);
`else
    chk_val("illegal_nop_pc_sel", int'(rps), 0);
    chk_val("illegal_nop_rf_we", int'(rfs), 0);
    chk_val("illegal_nop_cycles", ncyc, 4);
`endif

    // Fetch timeout: memory never answers
    do_reset();
    idle_go();
    do_instr(OP_I, 1'b1, 1'b0, 1'b0, 1'b0, 99, 0, 1'b1, 1'b0, ncyc, rps, rfs, stp);
    chk_val("fetch_timeout_cycles", ncyc, WM);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); run = 1'b1; mem_ready = 1'($urandom); #1;
      chk("halt_hold", 3'd6, 0, 0, 0, 0, 0, 2'b00, 0);
    end
    do_reset();

    // Data-memory timeout on a load
    idle_go();
    do_instr(OP_LD, 1'b1, 1'b0, 1'b0, 1'b0, 0, 99, 1'b1, 1'b0, ncyc, rps, rfs, stp);
    chk_val("mem_timeout_halted", int'(stp), 1);
    do_reset();

    // Reset while a store is waiting in MEM
    idle_go();
    do_instr(OP_I, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, ncyc, rps, rfs, stp);
    do_instr(OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, ncyc, rps, rfs, stp);
    @(negedge clk);
    inst = 32'h00112023; RegWr = 1'b0; Branch = 1'b0; MemWr = 1'b1; mem_ready = 1'b1; #1;
    chk("sw_fetch", 3'd1, 1, 0, 0, 1, 0, 2'b00, 0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("sw_decode", 3'd2, 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk); #1;
    chk("sw_exec", 3'd3, 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk); #1;
    chk("sw_mem", 3'd4, 0, 1, 1, 0, 0, 2'b00, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("sw_mem_rst", 3'd4, 0, 1, 1, 0, 0, 2'b00, 0);
    @(negedge clk); mem_ready = 1'b1;
    m_instret = '0; m_err = 1'b0; m_trap = 1'b0; #1;
    chk("rst_mid_mem", 3'd0, 0, 0, 0, 0, 0, 2'b00, 0);
    rst = 1'b0; run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      chk("late_ready_ignored", 3'd0, 0, 0, 0, 0, 0, 2'b00, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
